// File: rtl/condicionador_pkg.sv
// -----------------------------------------------------------------------------
// condicionador_pkg
// Shared definitions for the push-button conditioner:
//   estado_t    - FSM state encoding; the codes are exported on db_estado
//   is_onehot4  - true when exactly one bit of a 4-bit code is set
// -----------------------------------------------------------------------------
package condicionador_pkg;

    typedef enum logic [3:0] {
        OCIOSO        = 4'd0,
        FILTRANDO     = 4'd1,
        PULSO         = 4'd2,
        ESPERA_SOLTAR = 4'd3,
        INVALIDO      = 4'd4
    } estado_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        // v & (v-1) clears the lowest set bit; nothing left means one bit only
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// -----------------------------------------------------------------------------
// sincronizador_2ff
// Two-stage synchroniser bringing asynchronous pins into the clock domain.
// Ports:
//   clock  in         - system clock, rising edge
//   reset  in         - synchronous, active-high; clears both stages
//   d      in  WIDTH  - asynchronous input bits
//   q      out WIDTH  - synchronised bits, two cycles of latency
// -----------------------------------------------------------------------------
module sincronizador_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
// Synchronises, debounces and validates the four raw game buttons, producing
// a clean one-hot level and a single-cycle pulse per accepted press.
// Ports:
//   clock          in     - system clock, rising edge
//   reset          in     - synchronous, active-high
//   botoes_brutos  in  4  - raw button pins, active-high, asynchronous
//   habilita       in     - low: accepted presses are swallowed silently
//   botoes         out 4  - one-hot code of the accepted button while held
//   jogada_feita   out    - one-cycle pulse per accepted press
//   multipla       out    - high while a rejected multi-button press is held
//   db_estado      out 4  - current FSM state code
// -----------------------------------------------------------------------------
module condicionador_botoes
    import condicionador_pkg::*;
#(
    parameter int unsigned N_DEBOUNCE = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes_brutos,
    input  logic       habilita,
    output logic [3:0] botoes,
    output logic       jogada_feita,
    output logic       multipla,
    output logic [3:0] db_estado
);

    localparam int unsigned    CW      = $clog2(N_DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_DEBOUNCE - 1);

    logic [3:0]    s;
    estado_t       estado_q, estado_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    botoes_q, botoes_d;
    logic          jogada_q, jogada_d;
    logic          multipla_q, multipla_d;

    sincronizador_2ff #(.WIDTH(4)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (botoes_brutos),
        .q     (s)
    );

    always_comb begin
        estado_d   = estado_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        botoes_d   = botoes_q;
        jogada_d   = 1'b0;
        multipla_d = 1'b0;
        // saturating increment: the counter never wraps back to zero
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

        case (estado_q)
            OCIOSO: begin
                botoes_d = '0;
                if (s != 4'b0000) begin
                    cand_d   = s;
                    cnt_d    = '0;
                    estado_d = FILTRANDO;
                end
            end
            FILTRANDO: begin
                botoes_d = '0;
                if (s != cand_q) begin
                    estado_d = OCIOSO;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = is_onehot4(cand_q) ? PULSO : INVALIDO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PULSO: begin
                // habilita is only looked at here; a disabled press still
                // has to be released before the next one is considered
                jogada_d = habilita;
                botoes_d = habilita ? cand_q : 4'b0000;
                cnt_d    = '0;
                estado_d = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                if (s != 4'b0000) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    botoes_d = '0;
                    estado_d = OCIOSO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            INVALIDO: begin
                multipla_d = 1'b1;
                botoes_d   = '0;
                if (s == 4'b0000) begin
                    cnt_d    = '0;
                    estado_d = ESPERA_SOLTAR;
                end
            end
            default: begin
                botoes_d = '0;
                cnt_d    = '0;
                estado_d = ESPERA_SOLTAR;
            end
        endcase
    end

    // Reset lands in ESPERA_SOLTAR so a button held across reset is ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= ESPERA_SOLTAR;
            cand_q     <= '0;
            cnt_q      <= '0;
            botoes_q   <= '0;
            jogada_q   <= 1'b0;
            multipla_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            botoes_q   <= botoes_d;
            jogada_q   <= jogada_d;
            multipla_q <= multipla_d;
        end
    end

    assign botoes       = botoes_q;
    assign jogada_feita = jogada_q;
    assign multipla     = multipla_q;
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// -----------------------------------------------------------------------------
// tb_condicionador_botoes
// Self-checking bench for condicionador_botoes with N_DEBOUNCE = 4.
// Expected values are queued with the cycle they apply to and compared when
// that cycle is sampled (on the falling edge).
// -----------------------------------------------------------------------------
module tb_condicionador_botoes;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes_brutos;
    logic       habilita;
    logic [3:0] botoes;
    logic       jogada_feita;
    logic       multipla;
    logic [3:0] db_estado;

    condicionador_botoes #(.N_DEBOUNCE(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .botoes_brutos (botoes_brutos),
        .habilita      (habilita),
        .botoes        (botoes),
        .jogada_feita  (jogada_feita),
        .multipla      (multipla),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    // index of the most recent rising edge
    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef enum int { K_BOT, K_JF, K_MULT, K_EST, K_PULSES } kind_e;

    typedef struct {
        int unsigned cyc;
        kind_e       kind;
        logic [3:0]  val;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        hab;
        logic [3:0]  raw;
        int unsigned len;
        int unsigned dp;
        logic [3:0]  bot;
        logic        mult;
        logic [3:0]  est;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int unsigned n_checks    = 0;
    int unsigned n_errors    = 0;
    int unsigned pulse_total = 0;
    int unsigned exp_pulses  = 0;

    task automatic push(input int unsigned c, input kind_e k, input logic [3:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic add_vec(input string n, input logic rst, input logic hab, input logic [3:0] raw,
                           input int unsigned len, input int unsigned dp, input logic [3:0] bot,
                           input logic [3:0] est);
        vec_t v;
        v.name = n; v.rst = rst; v.hab = hab; v.raw = raw; v.len = len;
        v.dp = dp; v.bot = bot; v.mult = 1'b0; v.est = est;
        vecs.push_back(v);
    endtask

    // advance one cycle, sample outputs and settle scoreboard entries due now
    task automatic tick();
        logic [3:0] act;
        @(negedge clock);
        if (jogada_feita === 1'b1) pulse_total++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    K_BOT:   act = botoes;
                    K_JF:    act = {3'b000, jogada_feita};
                    K_MULT:  act = {3'b000, multipla};
                    K_EST:   act = db_estado;
                    default: act = (pulse_total > 15) ? 4'hF : pulse_total[3:0];
                endcase
                n_checks++;
                if (act !== sb[i].val) begin
                    n_errors++;
                    $display("FAIL %s cycle=%0d got=%b want=%b", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic drive(input logic [3:0] raw, input logic hab, input logic rst, input int unsigned len);
        botoes_brutos = raw;
        habilita      = hab;
        reset         = rst;
        for (int unsigned i = 0; i < len; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        int unsigned r;
        int unsigned c;

        // bounce while pressing, then bounce while releasing
        add_vec("bnc_t0",      1'b0, 1'b1, 4'b0100, 1, 0, 4'b0000, 4'd0);
        add_vec("bnc_t1",      1'b0, 1'b1, 4'b0000, 1, 0, 4'b0000, 4'd0);
        add_vec("bnc_t2",      1'b0, 1'b1, 4'b0100, 1, 0, 4'b0000, 4'd1);
        add_vec("bnc_t3",      1'b0, 1'b1, 4'b0000, 1, 0, 4'b0000, 4'd0);
        add_vec("bnc_t4",      1'b0, 1'b1, 4'b0100, 1, 0, 4'b0000, 4'd1);
        add_vec("bnc_t5",      1'b0, 1'b1, 4'b0000, 1, 0, 4'b0000, 4'd0);
        add_vec("bnc_hold",    1'b0, 1'b1, 4'b0100, 12, 1, 4'b0100, 4'd3);
        add_vec("rel_t0",      1'b0, 1'b1, 4'b0000, 1, 0, 4'b0100, 4'd3);
        add_vec("rel_t1",      1'b0, 1'b1, 4'b0100, 1, 0, 4'b0100, 4'd3);
        add_vec("rel_t2",      1'b0, 1'b1, 4'b0000, 1, 0, 4'b0100, 4'd3);
        add_vec("rel_t3",      1'b0, 1'b1, 4'b0100, 1, 0, 4'b0100, 4'd3);
        add_vec("rel_t4",      1'b0, 1'b1, 4'b0000, 1, 0, 4'b0100, 4'd3);
        add_vec("rel_t5",      1'b0, 1'b1, 4'b0100, 1, 0, 4'b0100, 4'd3);
        add_vec("rel_final",   1'b0, 1'b1, 4'b0000, 10, 0, 4'b0000, 4'd0);
        // disabled press, enabling mid-hold, then a fresh enabled press
        add_vec("dis_press",   1'b0, 1'b0, 4'b1000, 10, 0, 4'b0000, 4'd3);
        add_vec("dis_enable",  1'b0, 1'b1, 4'b1000, 10, 0, 4'b0000, 4'd3);
        add_vec("dis_release", 1'b0, 1'b1, 4'b0000, 10, 0, 4'b0000, 4'd0);
        add_vec("dis_fresh",   1'b0, 1'b1, 4'b1000, 10, 1, 4'b1000, 4'd3);
        add_vec("dis_rel2",    1'b0, 1'b1, 4'b0000, 10, 0, 4'b0000, 4'd0);
        // reset pulse while a button is held
        add_vec("rh_press",    1'b0, 1'b1, 4'b0001, 3, 0, 4'b0000, 4'd1);
        add_vec("rh_reset",    1'b1, 1'b1, 4'b0001, 1, 0, 4'b0000, 4'd3);
        add_vec("rh_hold",     1'b0, 1'b1, 4'b0001, 20, 0, 4'b0000, 4'd3);
        add_vec("rh_release",  1'b0, 1'b1, 4'b0000, 10, 0, 4'b0000, 4'd0);
        add_vec("rh_fresh",    1'b0, 1'b1, 4'b0001, 10, 1, 4'b0001, 4'd3);
        add_vec("rh_rel2",     1'b0, 1'b1, 4'b0000, 10, 0, 4'b0000, 4'd0);
        // two-cycle glitch
        add_vec("gl_on",       1'b0, 1'b1, 4'b0001, 2, 0, 4'b0000, 4'd0);
        add_vec("gl_off1",     1'b0, 1'b1, 4'b0000, 1, 0, 4'b0000, 4'd1);
        add_vec("gl_off2",     1'b0, 1'b1, 4'b0000, 5, 0, 4'b0000, 4'd0);

        // reset state
        t = cyc + 1;
        push(t + 2, K_EST,  4'd3,    "rst_estado");
        push(t + 2, K_BOT,  4'b0000, "rst_botoes");
        push(t + 2, K_JF,   4'd0,    "rst_jogada");
        push(t + 2, K_MULT, 4'd0,    "rst_multipla");
        drive(4'b0000, 1'b1, 1'b1, 3);
        push(cyc + 8, K_EST, 4'd0, "idle_estado");
        drive(4'b0000, 1'b1, 1'b0, 8);

        // clean press of 0010 held for 20 cycles
        t = cyc + 1;
        push(t + 6,  K_JF,  4'd0,    "clean_jf_early");
        push(t + 7,  K_JF,  4'd1,    "clean_jf");
        push(t + 7,  K_BOT, 4'b0010, "clean_botoes");
        push(t + 7,  K_EST, 4'd3,    "clean_estado");
        push(t + 8,  K_JF,  4'd0,    "clean_jf_once");
        push(t + 19, K_BOT, 4'b0010, "clean_botoes_held");
        drive(4'b0010, 1'b1, 1'b0, 20);
        r = cyc + 1;
        push(r + 4, K_BOT,    4'b0010, "clean_botoes_releasing");
        push(r + 7, K_BOT,    4'b0000, "clean_botoes_cleared");
        push(r + 7, K_EST,    4'd0,    "clean_estado_idle");
        push(r + 9, K_PULSES, 4'd1,    "clean_pulses");
        drive(4'b0000, 1'b1, 1'b0, 10);

        // multi-button press 0101 held for 15 cycles
        t = cyc + 1;
        push(t + 6,  K_MULT, 4'd0,    "mult_early");
        push(t + 7,  K_MULT, 4'd1,    "mult_set");
        push(t + 7,  K_EST,  4'd4,    "mult_estado");
        push(t + 14, K_MULT, 4'd1,    "mult_held");
        push(t + 14, K_BOT,  4'b0000, "mult_botoes");
        push(t + 14, K_JF,   4'd0,    "mult_jf");
        drive(4'b0101, 1'b1, 1'b0, 15);
        r = cyc + 1;
        push(r + 4, K_MULT,   4'd0, "mult_fall");
        push(r + 4, K_EST,    4'd3, "mult_espera");
        push(r + 9, K_EST,    4'd0, "mult_idle");
        push(r + 9, K_PULSES, 4'd1, "mult_pulses");
        drive(4'b0000, 1'b1, 1'b0, 10);

        exp_pulses = 1;
        foreach (vecs[i]) begin
            exp_pulses += vecs[i].dp;
            c = cyc + vecs[i].len;
            push(c, K_BOT,    vecs[i].bot,           {vecs[i].name, "_botoes"});
            push(c, K_MULT,   {3'b000, vecs[i].mult}, {vecs[i].name, "_multipla"});
            push(c, K_EST,    vecs[i].est,           {vecs[i].name, "_estado"});
            push(c, K_PULSES, 4'(exp_pulses),        {vecs[i].name, "_pulses"});
            drive(vecs[i].raw, vecs[i].hab, vecs[i].rst, vecs[i].len);
        end

        drive(4'b0000, 1'b1, 1'b0, 3);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
